mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Arbiter and sequencer for the single byte-wide port of spram8_128k (17-bit address, 8-bit data, 1-cycle registered read).
- Shares the port between three requesters:
  - 0: exec opcode/operand fetch
  - 1: data-memory load/store
  - 2: host loader
- Round-robin arbitration; locked bursts allow multi-byte (e.g. 32-bit cell) accesses.
- Read data is returned with a valid strobe to the issuing requester.

Parameters:
- NREQ, 3, number of requesters.
- ASZ, 17, byte address width.
- DSZ, 8, memory data width.
- MAXB, 8, maximum transfers per grant before forced release (anti-starvation).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
- req  in  NREQ  per-requester access request, held until transfer.
- lock  in  NREQ  per-requester burst hold; keep grant after current transfer.
- we  in  NREQ  per-requester write enable.
- ai  in  NREQ*ASZ  per-requester byte address, packed, requester i at [i*ASZ +: ASZ].
- vi  in  NREQ*DSZ  per-requester write data, packed.
- gnt  out  NREQ  one-hot grant; transfer occurs when gnt[i] & req[i].
- rvld  out  NREQ  one-hot read-data valid, one cycle after a read transfer.
- vo  out  DSZ  read data, broadcast; qualify with rvld.
- m_we  out  1  memory write enable.
- m_ai  out  ASZ  memory address.
- m_vi  out  DSZ  memory write data.
- m_vo  in  DSZ  memory read data (registered inside memory).

Behaviour:
- Reset (rst=0):
  - State IDLE; owner=0; burst count bc=0.
  - RR pointer ptr=NREQ-1, so requester 0 wins first.
  - gnt=0, rvld=0, m_we=0, m_ai=0, m_vi=0.
  - Any pending read-valid is discarded.
- States:
  - IDLE: no owner, memory port idle (m_we=0).
  - BUSY: owner latched, gnt[owner]=1.
- IDLE -> BUSY:
  - Any req bit set: winner = first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
  - Latch owner=winner, set ptr=winner, bc=0; BUSY next cycle.
  - Grant latency is 1 cycle from req to gnt.
- BUSY, combinational outputs:
  - gnt[owner]=1, all other gnt bits 0.
  - m_ai = ai[owner], m_vi = vi[owner].
  - m_we = we[owner] & req[owner].
- Transfer:
  - A cycle in BUSY with req[owner]=1. On each transfer, bc increments.
  - A read transfer (we=0) sets rvld[owner]=1 in the next cycle, with vo=m_vo.
  - rvld is a registered copy of the issuing owner and is independent of later grant changes.
- Release (BUSY -> next):
  - Causes: a transfer with lock[owner]=0; req[owner]=0 (no transfer that cycle); or a transfer where bc reaches MAXB-1 (forced release even when lock=1).
  - On release, re-arbitrate in the same cycle over req excluding the current owner.
  - If another requester is pending: the winner becomes owner next cycle (back-to-back, no IDLE bubble).
  - Else: IDLE next cycle.
  - The released owner re-requesting wins only after others are served (fairness).
- Simultaneous req from all three with ptr=2: order of service is 0, 1, 2, 0, ...
- Write followed by read of the same address by the same owner in the next transfer returns the new data (memory write-first not required; the access is one cycle later).
- Mid-operation reset: burst aborted, no rvld emitted, memory writes stop immediately (m_we forced 0 asynchronously).
- Address and data widths pass through unmodified; no address wrap handling here. Requesters own increment and wrap of ai.

Decomposition:
- Shared package mem_pkg:
  - typedef arb_st_e {IDLE, BUSY}
  - localparams ASZ=17 and DSZ=8 reused by spram8_128k/exec
  - requester index constants REQ_XU=0, REQ_DS=1, REQ_HOST=2
- Sub-module rr_pick: combinational round-robin priority pick. Inputs: request vector, pointer, exclude mask. Outputs: one-hot winner and valid. Used for both the IDLE pick and the release pick.

Test Plan:
- Reset with req=3'b111 held: gnt=0 during reset; first gnt=3'b001 one cycle after rst rises; then 3'b010, 3'b100, 3'b001 on successive cycles (lock=0).
- Requester 2 writes 0xA5 to 0x100 (we=1), then requester 0 reads 0x100: m_we pulses once at 0x100; rvld[0]=1 one cycle after the read transfer with vo=0xA5.
- Requester 0 lock=1 for a 4-byte fetch at 0x100..0x103 holding data 0,1,2,3 while req[1]=1: gnt stays 3'b001 for 4 transfers; rvld[0] on 4 consecutive cycles with vo=0,1,2,3; gnt moves to 3'b010 immediately after.
- Requester 1 lock=1 continuously with req[0]=1: forced release after exactly MAXB=8 transfers; gnt switches to 3'b001 the next cycle.
- Owner drops req with lock=1 and no other requester: state returns to IDLE next cycle, gnt=0, m_we=0.
- Assert rst low during requester 2's burst at transfer 2: gnt, rvld and m_we are 0 in the same cycle. After release, requester 0 wins first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory subsystem: arbiter states,
// port widths and requester indices.
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_st_e;

  localparam int ASZ = 17;
  localparam int DSZ = 8;

  localparam int REQ_XU   = 0;
  localparam int REQ_DS   = 1;
  localparam int REQ_HOST = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after ptr (modulo N) that is
// requesting and not excluded.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic          vld
);

  logic [N-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    cand = req & ~excl;
    win  = '0;
    vld  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!vld && cand[(int'(ptr) + i) % N]) begin
        win[(int'(ptr) + i) % N] = 1'b1;
        vld                      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter/sequencer sharing one byte-wide registered-read memory
// port between NREQ requesters, with locked bursts capped at MAXB transfers.
module mem_arb #(
  parameter int NREQ = 3,
  parameter int ASZ  = mem_pkg::ASZ,
  parameter int DSZ  = mem_pkg::DSZ,
  parameter int MAXB = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ-1:0]     we,
  input  logic [NREQ*ASZ-1:0] ai,
  input  logic [NREQ*DSZ-1:0] vi,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rvld,
  output logic [DSZ-1:0]      vo,
  output logic                m_we,
  output logic [ASZ-1:0]      m_ai,
  output logic [DSZ-1:0]      m_vi,
  input  logic [DSZ-1:0]      m_vo
);
  import mem_pkg::*;

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXB);

  arb_st_e         st, st_n;
  logic [OW-1:0]   owner, owner_n, ptr, ptr_n, pick_idx;
  logic [BW-1:0]   bc, bc_n;
  logic [NREQ-1:0] rvld_q, rvld_n;
  logic [NREQ-1:0] own_oh, excl, pick_win;
  logic            pick_vld, busy, xfer;

  assign busy = (st == BUSY);
  assign xfer = busy && req[owner];

  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
  end

  // While busy the owner is excluded, so one picker serves both the idle
  // pick and the back-to-back release pick (ptr equals owner while busy).
  assign excl = busy ? own_oh : '0;

  rr_pick #(.N(NREQ), .PW(OW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .excl (excl),
    .win  (pick_win),
    .vld  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win[i]) pick_idx = OW'(i);
    end
  end

  // Port outputs derive from the async-reset state, so reset silences them at once.
  assign gnt  = busy ? own_oh : '0;
  assign m_we = xfer && we[owner];
  assign m_ai = busy ? ai[int'(owner)*ASZ +: ASZ] : '0;
  assign m_vi = busy ? vi[int'(owner)*DSZ +: DSZ] : '0;
  assign rvld = rvld_q;
  assign vo   = m_vo;

  always_comb begin
    st_n    = st;
    owner_n = owner;
    ptr_n   = ptr;
    bc_n    = bc;
    rvld_n  = '0;
    case (st)
      IDLE: begin
        if (pick_vld) begin
          st_n    = BUSY;
          owner_n = pick_idx;
          ptr_n   = pick_idx;
          bc_n    = '0;
        end
      end
      BUSY: begin
        if (xfer) begin
          bc_n = bc + 1'b1;
          if (!we[owner]) rvld_n = own_oh;
        end
        if (!xfer || !lock[owner] || bc == BW'(MAXB - 1)) begin
          bc_n = '0;
          if (pick_vld) begin
            owner_n = pick_idx;
            ptr_n   = pick_idx;
          end else begin
            st_n = IDLE;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= IDLE;
      owner  <= '0;
      ptr    <= OW'(NREQ - 1);
      bc     <= '0;
      rvld_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      st     <= st_n;
      owner  <= owner_n;
      ptr    <= ptr_n;
      bc     <= bc_n;
      rvld_q <= rvld_n;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a round-robin vector table plus hand-written
// sequences for writes/reads, locked bursts, forced release and mid-burst reset.
module tb_mem_arb;

  localparam int NREQ = 3;
  localparam int ASZ  = 17;
  localparam int DSZ  = 8;

  logic                clk, rst;
  logic [NREQ-1:0]     req, lock, we, gnt, rvld;
  logic [NREQ*ASZ-1:0] ai;
  logic [NREQ*DSZ-1:0] vi;
  logic [DSZ-1:0]      vo, m_vi, m_vo;
  logic                m_we;
  logic [ASZ-1:0]      m_ai;
  logic [ASZ-1:0]      a [NREQ];
  logic [DSZ-1:0]      v [NREQ];
  logic [7:0]          mem [0:1023];

  int errors = 0;
  int checks = 0;

  assign ai = {a[2], a[1], a[0]};
  assign vi = {v[2], v[1], v[0]};

  mem_arb #(.NREQ(NREQ), .ASZ(ASZ), .DSZ(DSZ), .MAXB(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .lock (lock),
    .we   (we),
    .ai   (ai),
    .vi   (vi),
    .gnt  (gnt),
    .rvld (rvld),
    .vo   (vo),
    .m_we (m_we),
    .m_ai (m_ai),
    .m_vi (m_vi),
    .m_vo (m_vo)
  );

  // Memory model: registered read, write applied on the same edge.
  always @(posedge clk) begin
    if (m_we) mem[m_ai[9:0]] <= m_vi;
    m_vo <= mem[m_ai[9:0]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] we;
    logic [2:0] gnt;
    logic [2:0] rvld;
    logic       mwe;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // Round-robin after reset with all three requesting, one write mixed in.
    tbl[0] = '{req: 3'b111, lock: 3'b000, we: 3'b000, gnt: 3'b000, rvld: 3'b000, mwe: 1'b0};
    tbl[1] = '{req: 3'b111, lock: 3'b000, we: 3'b000, gnt: 3'b001, rvld: 3'b000, mwe: 1'b0};
    tbl[2] = '{req: 3'b111, lock: 3'b000, we: 3'b000, gnt: 3'b010, rvld: 3'b001, mwe: 1'b0};
    tbl[3] = '{req: 3'b111, lock: 3'b000, we: 3'b100, gnt: 3'b100, rvld: 3'b010, mwe: 1'b1};
    tbl[4] = '{req: 3'b111, lock: 3'b000, we: 3'b000, gnt: 3'b001, rvld: 3'b000, mwe: 1'b0};
    tbl[5] = '{req: 3'b000, lock: 3'b000, we: 3'b000, gnt: 3'b010, rvld: 3'b001, mwe: 1'b0};
    tbl[6] = '{req: 3'b000, lock: 3'b000, we: 3'b000, gnt: 3'b000, rvld: 3'b000, mwe: 1'b0};

    rst  = 1'b0;
    req  = 3'b111;
    lock = 3'b000;
    we   = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      v[i] = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_rvld", 32'(rvld), 32'h0);
    check("reset_m_we", 32'(m_we), 32'h0);
    check("reset_m_ai", 32'(m_ai), 32'h0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst  = 1'b1;
      req  = tbl[i].req;
      lock = tbl[i].lock;
      we   = tbl[i].we;
      #1;
      check($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("rr%0d_rvld", i), 32'(rvld), 32'(tbl[i].rvld));
      check($sformatf("rr%0d_m_we", i), 32'(m_we), 32'(tbl[i].mwe));
    end

    // Requester 2 writes 0xA5 to 0x100, requester 0 reads it back.
    @(negedge clk);
    req = 3'b100; we = 3'b100; a[2] = 17'h100; v[2] = 8'hA5;
    #1;
    check("wr_idle_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    req = 3'b101; a[0] = 17'h100;
    #1;
    check("wr_gnt", 32'(gnt), 32'h4);
    check("wr_m_we", 32'(m_we), 32'h1);
    check("wr_m_ai", 32'(m_ai), 32'h100);
    check("wr_m_vi", 32'(m_vi), 32'hA5);
    @(negedge clk);
    req = 3'b001; we = 3'b000;
    #1;
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_m_we", 32'(m_we), 32'h0);
    check("rd_m_ai", 32'(m_ai), 32'h100);
    @(negedge clk);
    req = 3'b000;
    #1;
    check("rd_idle_gnt", 32'(gnt), 32'h0);
    check("rd_rvld", 32'(rvld), 32'h1);
    check("rd_vo", 32'(vo), 32'hA5);

    // Host loads 0,1,2,3 into 0x100..0x103 as a locked write burst.
    @(negedge clk);
    req = 3'b100; lock = 3'b100; we = 3'b100; a[2] = 17'h100; v[2] = 8'h00;
    #1;
    check("load_idle_gnt", 32'(gnt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a[2] = 17'(17'h100 + k);
      v[2] = 8'(k);
      lock = (k < 3) ? 3'b100 : 3'b000;
      #1;
      check($sformatf("load%0d_gnt", k), 32'(gnt), 32'h4);
      check($sformatf("load%0d_m_we", k), 32'(m_we), 32'h1);
    end

    // Requester 0 locked 4-byte fetch while requester 1 waits.
    @(negedge clk);
    req = 3'b011; lock = 3'b001; we = 3'b000; a[0] = 17'h100; a[1] = 17'h0;
    #1;
    check("burst_idle_gnt", 32'(gnt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a[0] = 17'(17'h100 + k);
      lock = (k < 3) ? 3'b001 : 3'b000;
      #1;
      check($sformatf("burst%0d_gnt", k), 32'(gnt), 32'h1);
      if (k > 0) begin
        check($sformatf("burst%0d_rvld", k), 32'(rvld), 32'h1);
        check($sformatf("burst%0d_vo", k), 32'(vo), 32'(k - 1));
      end
    end

    // Handover to requester 1, which then holds lock until forced release.
    @(negedge clk);
    req = 3'b011; lock = 3'b010;
    #1;
    check("hand_gnt", 32'(gnt), 32'h2);
    check("hand_rvld", 32'(rvld), 32'h1);
    check("hand_vo", 32'(vo), 32'h3);
    for (int t = 1; t < 8; t++) begin
      @(negedge clk);
      #1;
      check($sformatf("maxb%0d_gnt", t), 32'(gnt), 32'h2);
      check($sformatf("maxb%0d_rvld", t), 32'(rvld), 32'h2);
    end
    @(negedge clk);
    req = 3'b000; lock = 3'b001;
    #1;
    check("forced_gnt", 32'(gnt), 32'h1);
    check("forced_rvld", 32'(rvld), 32'h2);

    // Owner 0 dropped req with lock held and nobody else waiting.
    @(negedge clk);
    #1;
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_m_we", 32'(m_we), 32'h0);
    check("drop_rvld", 32'(rvld), 32'h0);

    // Reset asserted during requester 2's burst on its third transfer.
    @(negedge clk);
    req = 3'b100; lock = 3'b100; we = 3'b100; a[2] = 17'h200; v[2] = 8'h11;
    #1;
    check("mr_idle_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    #1;
    check("mr0_gnt", 32'(gnt), 32'h4);
    check("mr0_m_we", 32'(m_we), 32'h1);
    @(negedge clk);
    we = 3'b000; a[2] = 17'h201;
    #1;
    check("mr1_gnt", 32'(gnt), 32'h4);
    check("mr1_m_we", 32'(m_we), 32'h0);
    @(negedge clk);
    we = 3'b100; a[2] = 17'h202;
    #1;
    check("mr2_gnt", 32'(gnt), 32'h4);
    check("mr2_m_we", 32'(m_we), 32'h1);
    check("mr2_rvld", 32'(rvld), 32'h4);
    rst = 1'b0;
    #1;
    check("mr_rst_gnt", 32'(gnt), 32'h0);
    check("mr_rst_m_we", 32'(m_we), 32'h0);
    check("mr_rst_rvld", 32'(rvld), 32'h0);
    req = 3'b111; lock = 3'b000; we = 3'b000;

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    #1;
    check("post_rst_first", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 3'b000;
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
